// File: rtl/scanout_pkg.sv
// Shared timing constants, colour types and colour-map helpers for the VRAM scanout block.
// The optional palette is enabled with the SCANOUT_PALETTE_EN macro.
package scanout_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef logic [11:0] rgb12_t;

   // Per-pixel control travelling down the scanout pipeline with the beam.
   typedef struct packed {
      logic vld;
      logic sx0;
      logic win;
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } pix_ctl_t;

   localparam pix_ctl_t PIX_CTL_IDLE = '{vld: 1'b0, sx0: 1'b0, win: 1'b0, de: 1'b0,
                                         hs: 1'b1, vs: 1'b1, fs: 1'b0};

   function automatic rgb12_t irgb_map(input logic [3:0] idx);
      logic [3:0] on_lvl;
      logic [3:0] off_lvl;
      on_lvl  = idx[3] ? 4'hF : 4'hA;
      off_lvl = idx[3] ? 4'h5 : 4'h0;
      return {idx[2] ? on_lvl : off_lvl,
              idx[1] ? on_lvl : off_lvl,
              idx[0] ? on_lvl : off_lvl};
   endfunction

   function automatic rgb12_t grey_ramp(input logic [3:0] idx);
      return {idx, idx, idx};
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Beam position counters with sync and active-area flags for the current position.
module vga_timing
   import scanout_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   output logic [9:0] h_o,
   output logic [9:0] v_o,
   output logic [9:0] h_next_o,
   output logic [9:0] v_next_o,
   output logic       line_end_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       active_o,
   output logic       frame_first_o
);

   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       line_end_s;

   // Next beam position: h wraps at end of line, v advances only on line wrap.
   always_comb begin
      h_d        = h_q;
      v_d        = v_q;
      line_end_s = (h_q == 10'(H_TOT - 1));
      if (line_end_s) begin
         h_d = 10'd0;
         if (v_q == 10'(V_TOT - 1)) begin
            v_d = 10'd0;
         end else begin
            v_d = v_q + 10'd1;
         end
      end else begin
         h_d = h_q + 10'd1;
      end
   end

   // Beam position registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         h_q <= 10'd0;
         v_q <= 10'd0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_o           = h_q;
   assign v_o           = v_q;
   assign h_next_o      = h_d;
   assign v_next_o      = v_d;
   assign line_end_o    = line_end_s;
   assign hsync_o       = !((int'(h_q) >= HS_START) && (int'(h_q) < HS_END));
   assign vsync_o       = !((int'(v_q) >= VS_START) && (int'(v_q) < VS_END));
   assign active_o      = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
   assign frame_first_o = (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: rtl/vram_scanout.sv
// VGA scanout of a 128x128 nibble-packed VRAM image, scaled and centred, 3-clock output latency.
// Define SCANOUT_PALETTE_EN for a writable 16-entry palette instead of the fixed IRGB map.
module vram_scanout
   import scanout_pkg::*;
#(
   parameter int     H_ACTIVE   = H_ACTIVE_DEF,
   parameter int     H_FP       = H_FP_DEF,
   parameter int     H_SYNC     = H_SYNC_DEF,
   parameter int     H_BP       = H_BP_DEF,
   parameter int     V_ACTIVE   = V_ACTIVE_DEF,
   parameter int     V_FP       = V_FP_DEF,
   parameter int     V_SYNC     = V_SYNC_DEF,
   parameter int     V_BP       = V_BP_DEF,
   parameter int     SCALE      = 3,
   parameter int     WIN_X      = 128,
   parameter int     WIN_Y      = 48,
   parameter rgb12_t BORDER_RGB = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [12:0] vram_addr,
   input  logic [7:0]  vram_data,
   input  logic        pal_we,
   input  logic [3:0]  pal_idx,
   input  logic [11:0] pal_rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam int         WIN_W   = 128 * SCALE;
   localparam logic [1:0] SUB_MAX = 2'(SCALE - 1);

   logic [9:0] h_s, v_s, h_nxt_s, v_nxt_s;
   logic       line_end_s, hs_s, vs_s, act_s, first_s;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .h_o           (h_s),
      .v_o           (v_s),
      .h_next_o      (h_nxt_s),
      .v_next_o      (v_nxt_s),
      .line_end_o    (line_end_s),
      .hsync_o       (hs_s),
      .vsync_o       (vs_s),
      .active_o      (act_s),
      .frame_first_o (first_s)
   );

   logic [1:0]  hsub_q, hsub_d, vsub_q, vsub_d;
   logic [6:0]  sx_q, sx_d, sy_q, sy_d;
   logic [12:0] addr_q, addr_d;
   logic        in_win_s;
   pix_ctl_t    s0_s, s1_q, s2_q;
   logic [3:0]  nib_s;
   rgb12_t      map_s, rgb_q, rgb_d;
   logic        de_q, hs_q, vs_q, fs_q;

   // Source coordinates for the current beam position; reloaded as the next position enters the window.
   always_comb begin
      hsub_d = hsub_q;
      sx_d   = sx_q;
      vsub_d = vsub_q;
      sy_d   = sy_q;
      if (h_nxt_s == 10'(WIN_X)) begin
         hsub_d = 2'd0;
         sx_d   = 7'd0;
      end else if (hsub_q == SUB_MAX) begin
         hsub_d = 2'd0;
         sx_d   = sx_q + 7'd1;
      end else begin
         hsub_d = hsub_q + 2'd1;
      end
      if (!line_end_s) begin
         vsub_d = vsub_q;
      end else if (v_nxt_s == 10'(WIN_Y)) begin
         vsub_d = 2'd0;
         sy_d   = 7'd0;
      end else if (vsub_q == SUB_MAX) begin
         vsub_d = 2'd0;
         sy_d   = sy_q + 7'd1;
      end else begin
         vsub_d = vsub_q + 2'd1;
      end
   end

   // S0 control word and the VRAM address, which holds outside the window.
   always_comb begin
      in_win_s = (int'(h_s) >= WIN_X) && (int'(h_s) < WIN_X + WIN_W) &&
                 (int'(v_s) >= WIN_Y) && (int'(v_s) < WIN_Y + WIN_W);
      s0_s     = PIX_CTL_IDLE;
      s0_s.vld = 1'b1;
      s0_s.sx0 = sx_q[0];
      s0_s.win = in_win_s;
      s0_s.de  = act_s;
      s0_s.hs  = hs_s;
      s0_s.vs  = vs_s;
      s0_s.fs  = first_s;
      if (in_win_s) begin
         addr_d = {sy_q, sx_q[6:1]};
      end else begin
         addr_d = addr_q;
      end
   end

`ifdef SCANOUT_PALETTE_EN
   rgb12_t pal_q [16];

   // Palette register file; a write is visible to the colour stage on the following clock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            pal_q[i] <= grey_ramp(4'(i));
         end
      end else if (pal_we) begin
         pal_q[pal_idx] <= pal_rgb;
      end
   end
`else
   logic unused_pal_s;
   assign unused_pal_s = ^{pal_we, pal_idx, pal_rgb};
`endif

   // S3 nibble unpack and colour selection.
   always_comb begin
      if (s2_q.sx0) begin
         nib_s = vram_data[7:4];
      end else begin
         nib_s = vram_data[3:0];
      end
`ifdef SCANOUT_PALETTE_EN
      map_s = pal_q[nib_s];
`else
      map_s = irgb_map(nib_s);
`endif
      if (!(s2_q.vld && s2_q.de)) begin
         rgb_d = 12'h000;
      end else if (s2_q.win) begin
         rgb_d = map_s;
      end else begin
         rgb_d = BORDER_RGB;
      end
   end

   // Window counters, address stage and delay line to the registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsub_q <= 2'd0;
         sx_q   <= 7'd0;
         vsub_q <= 2'd0;
         sy_q   <= 7'd0;
         addr_q <= 13'd0;
         s1_q   <= PIX_CTL_IDLE;
         s2_q   <= PIX_CTL_IDLE;
         rgb_q  <= 12'h000;
         de_q   <= 1'b0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         fs_q   <= 1'b0;
      end else begin
         hsub_q <= hsub_d;
         sx_q   <= sx_d;
         vsub_q <= vsub_d;
         sy_q   <= sy_d;
         addr_q <= addr_d;
         s1_q   <= s0_s;
         s2_q   <= s1_q;
         rgb_q  <= rgb_d;
         de_q   <= s2_q.vld & s2_q.de;
         hs_q   <= s2_q.hs;
         vs_q   <= s2_q.vs;
         fs_q   <= s2_q.vld & s2_q.fs;
      end
   end

   assign vram_addr   = addr_q;
   assign rgb         = rgb_q;
   assign de          = de_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;

endmodule
